// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and helpers for the general register file family
package rf_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int REG_ZERO = 0;

   // Address width that never collapses to zero bits for tiny register counts.
   function automatic int clog2_safe(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/grg_mp_if.sv
// rtl/grg_mp_if.sv - read/write/issue bundle of the multi-port register file
interface grg_mp_if
   import rf_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRD  = 2,
   parameter int NWR  = 2
);
   localparam int AW = clog2_safe(NREG);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NWR-1:0]      we;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                iss_valid;
   logic [AW-1:0]       iss_rd;
   logic [NREG-1:0]     busy_vec;

   modport master (
      output rd_addr, we, wr_addr, wr_data, iss_valid, iss_rd,
      input  rd_data, rd_busy, busy_vec
   );

   modport slave (
      input  rd_addr, we, wr_addr, wr_data, iss_valid, iss_rd,
      output rd_data, rd_busy, busy_vec
   );

endinterface

// File: rtl/grg_scoreboard.sv
// rtl/grg_scoreboard.sv - per-register busy bits; issue sets, writeback clears, set wins
module grg_scoreboard
   import rf_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int NWR  = 2,
   parameter int AW   = clog2_safe(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd,
   input  logic [NWR-1:0]    we,
   input  logic [NWR*AW-1:0] wr_addr,
   output logic [NREG-1:0]   busy_vec
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int j = 0; j < NWR; j++) begin
         if (we[j]) busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
      // Applied after the clears so a new producer supersedes the retiring one.
      if (iss_valid) busy_d[iss_rd] = 1'b1;
      busy_d[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/grg_mp.sv
// rtl/grg_mp.sv - multi-port register file: NWR sync writes, NRD comb reads, optional bypass
module grg_mp
   import rf_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREG   = NREG_DEF,
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int BYPASS = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   grg_mp_if.slave  bus
);

   localparam int AW = clog2_safe(NREG);
   localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

   logic [XLEN-1:0]     regs_q [NREG];
   logic [XLEN-1:0]     regs_d [NREG];
   logic [NRD*XLEN-1:0] rd_data_c;
   logic [NRD-1:0]      rd_busy_c;
   logic [NREG-1:0]     busy_w;
   logic [AW-1:0]       ra;

   // Ascending port order lets the highest-index writer win on a conflict.
   always_comb begin
      regs_d = regs_q;
      for (int j = 0; j < NWR; j++) begin
         if (bus.we[j] && (bus.wr_addr[j*AW +: AW] != ZERO_A)) begin
            regs_d[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Bypass is suppressed in reset so held-low rst_n reads back all zeros.
   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      ra        = '0;
      for (int k = 0; k < NRD; k++) begin
         ra = bus.rd_addr[k*AW +: AW];
         rd_data_c[k*XLEN +: XLEN] = regs_q[ra];
         if ((BYPASS != 0) && rst_n) begin
            for (int j = 0; j < NWR; j++) begin
               if (bus.we[j] && (bus.wr_addr[j*AW +: AW] == ra)) begin
                  rd_data_c[k*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
               end
            end
         end
         if (ra == ZERO_A) rd_data_c[k*XLEN +: XLEN] = '0;
         rd_busy_c[k] = busy_w[ra];
      end
   end

   grg_scoreboard #(
      .NREG (NREG),
      .NWR  (NWR),
      .AW   (AW)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_valid (bus.iss_valid),
      .iss_rd    (bus.iss_rd),
      .we        (bus.we),
      .wr_addr   (bus.wr_addr),
      .busy_vec  (busy_w)
   );

   assign bus.rd_data  = rd_data_c;
   assign bus.rd_busy  = rd_busy_c;
   assign bus.busy_vec = busy_w;

endmodule

// File: tb/tb_grg_mp.sv
// tb/tb_grg_mp.sv - directed and randomized checks of grg_mp against a register/scoreboard model
module tb_grg_mp;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic clk;
   logic rst_n;

   grg_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(4), .NWR(2)) ia ();
   grg_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2)) ib ();

   grg_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(4), .NWR(2), .BYPASS(1)) dut_a (
      .clk (clk), .rst_n (rst_n), .bus (ia.slave)
   );
   grg_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2), .BYPASS(0)) dut_b (
      .clk (clk), .rst_n (rst_n), .bus (ib.slave)
   );

   assign ib.rd_addr   = ia.rd_addr[2*AW-1:0];
   assign ib.we        = ia.we;
   assign ib.wr_addr   = ia.wr_addr;
   assign ib.wr_data   = ia.wr_data;
   assign ib.iss_valid = ia.iss_valid;
   assign ib.iss_rd    = ia.iss_rd;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   logic [AW-1:0]   cur_rd [4];
   logic [1:0]      cur_we;
   logic [AW-1:0]   cur_wa [2];
   logic [XLEN-1:0] cur_wd [2];
   logic            cur_iv;
   logic [AW-1:0]   cur_ird;

   logic [XLEN-1:0] m_reg  [NREG];
   bit              m_busy [NREG];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic apply();
      for (int k = 0; k < 4; k++) ia.rd_addr[k*AW +: AW] = cur_rd[k];
      ia.we = cur_we;
      for (int j = 0; j < 2; j++) begin
         ia.wr_addr[j*AW +: AW]     = cur_wa[j];
         ia.wr_data[j*XLEN +: XLEN] = cur_wd[j];
      end
      ia.iss_valid = cur_iv;
      ia.iss_rd    = cur_ird;
   endtask

   task automatic idle();
      for (int k = 0; k < 4; k++) cur_rd[k] = '0;
      cur_we = '0;
      for (int j = 0; j < 2; j++) begin
         cur_wa[j] = '0;
         cur_wd[j] = '0;
      end
      cur_iv  = 1'b0;
      cur_ird = '0;
      apply();
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_reg[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   // Architectural effect of one rising edge: writes in port order, then retire, then issue.
   task automatic model_tick();
      if (rst_n) begin
         for (int j = 0; j < 2; j++) begin
            if (cur_we[j]) begin
               if (cur_wa[j] != 0) m_reg[cur_wa[j]] = cur_wd[j];
               m_busy[cur_wa[j]] = 1'b0;
            end
         end
         if (cur_iv && cur_ird != 0) m_busy[cur_ird] = 1'b1;
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [AW-1:0] a, input bit byp);
      logic [31:0] r;
      if (a == 0) return '0;
      r = m_reg[a];
      if (byp && rst_n) begin
         for (int j = 0; j < 2; j++) if (cur_we[j] && cur_wa[j] == a) r = cur_wd[j];
      end
      return r;
   endfunction

   function automatic logic [31:0] exp_busy();
      logic [31:0] r;
      for (int i = 0; i < NREG; i++) r[i] = m_busy[i];
      return r;
   endfunction

   task automatic check_outputs();
      for (int k = 0; k < 4; k++) begin
         check_eq("a_rd_data", ia.rd_data[k*XLEN +: XLEN], exp_rd(cur_rd[k], 1'b1));
         check_eq("a_rd_busy", 32'(ia.rd_busy[k]), 32'(m_busy[cur_rd[k]]));
      end
      for (int k = 0; k < 2; k++) begin
         check_eq("b_rd_data", ib.rd_data[k*XLEN +: XLEN], exp_rd(cur_rd[k], 1'b0));
      end
      check_eq("a_busy_vec", ia.busy_vec, exp_busy());
      check_eq("b_busy_vec", ib.busy_vec, exp_busy());
   endtask

   task automatic cyc();
      @(posedge clk);
      model_tick();
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      model_reset();
      idle();
      #1;
      check_eq("reset_busy_vec", ia.busy_vec, 32'h0);
      check_eq("reset_rd_data", ia.rd_data[31:0], 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Asynchronous reset in the middle of activity.
      cur_we = 2'b01; cur_wa[0] = 5; cur_wd[0] = 32'hDEADBEEF;
      cur_iv = 1'b1;  cur_ird = 7;
      apply();
      cyc();
      idle();
      cur_rd[0] = 5; apply();
      #1;
      check_eq("pre_rst_x5", ia.rd_data[31:0], 32'hDEADBEEF);
      check_eq("pre_rst_busy", ia.busy_vec, 32'h0000_0080);
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_x5", ia.rd_data[31:0], 32'h0);
      check_eq("async_rst_busy", ia.busy_vec, 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Two ports, two registers, same cycle.
      idle();
      cur_we = 2'b11;
      cur_wa[0] = 3; cur_wd[0] = 32'h11111111;
      cur_wa[1] = 4; cur_wd[1] = 32'h22222222;
      apply();
      cyc();
      idle();
      cur_rd[0] = 3; cur_rd[1] = 4; apply();
      #1;
      check_eq("mp_x3", ia.rd_data[31:0], 32'h11111111);
      check_eq("mp_x4", ia.rd_data[63:32], 32'h22222222);

      // Same-address conflict: higher port wins.
      idle();
      cur_we = 2'b11;
      cur_wa[0] = 9; cur_wd[0] = 32'hAAAA0000;
      cur_wa[1] = 9; cur_wd[1] = 32'h5555FFFF;
      apply();
      cyc();
      idle();
      cur_rd[0] = 9; apply();
      #1;
      check_eq("conflict_a", ia.rd_data[31:0], 32'h5555FFFF);
      check_eq("conflict_b", ib.rd_data[31:0], 32'h5555FFFF);

      // x0 stays zero, even with a same-cycle write to it.
      idle();
      cur_we = 2'b01; cur_wa[0] = 0; cur_wd[0] = 32'hFFFFFFFF;
      apply();
      #1;
      check_eq("x0_same_cycle", ia.rd_data[31:0], 32'h0);
      cyc();
      idle();
      #1;
      check_eq("x0_after", ia.rd_data[31:0], 32'h0);

      // Bypass vs. no bypass on x10.
      cur_we = 2'b01; cur_wa[0] = 10; cur_wd[0] = 32'h0BADF00D; apply();
      cyc();
      cur_wd[0] = 32'h12345678; cur_rd[0] = 10; apply();
      #1;
      check_eq("bypass_a", ia.rd_data[31:0], 32'h12345678);
      check_eq("nobypass_b_old", ib.rd_data[31:0], 32'h0BADF00D);
      cyc();
      idle();
      cur_rd[0] = 10; apply();
      #1;
      check_eq("nobypass_b_new", ib.rd_data[31:0], 32'h12345678);
      check_eq("bypass_a_held", ia.rd_data[31:0], 32'h12345678);

      // Scoreboard: set, conservative clear, set-wins, x0 never busy.
      idle();
      cur_iv = 1'b1; cur_ird = 6; cur_rd[0] = 6; apply();
      #1;
      check_eq("busy_before_issue", 32'(ia.rd_busy[0]), 32'h0);
      cyc();
      idle();
      cur_rd[0] = 6; apply();
      #1;
      check_eq("busy_after_issue", 32'(ia.rd_busy[0]), 32'h1);
      cur_we = 2'b01; cur_wa[0] = 6; cur_wd[0] = 32'h66; apply();
      #1;
      check_eq("busy_during_wb", 32'(ia.rd_busy[0]), 32'h1);
      cyc();
      idle();
      cur_rd[0] = 6; apply();
      #1;
      check_eq("busy_after_wb", 32'(ia.rd_busy[0]), 32'h0);
      cur_iv = 1'b1; cur_ird = 6;
      cur_we = 2'b10; cur_wa[1] = 6; cur_wd[1] = 32'h67; apply();
      cyc();
      idle();
      cur_rd[0] = 6; apply();
      #1;
      check_eq("set_wins", 32'(ia.rd_busy[0]), 32'h1);
      cur_iv = 1'b1; cur_ird = 0; apply();
      cyc();
      idle();
      #1;
      check_eq("x0_never_busy", 32'(ia.busy_vec[0]), 32'h0);
      check_eq("busy_vec_x6", ia.busy_vec, 32'h0000_0040);

      // Randomized regression with occasional asynchronous reset pulses.
      for (int c = 0; c < 10000; c++) begin
         for (int k = 0; k < 4; k++)
            cur_rd[k] = AW'($urandom_range(0, 1) ? $urandom_range(0, 31) : $urandom_range(0, 3));
         for (int j = 0; j < 2; j++) begin
            cur_wa[j] = AW'($urandom_range(0, 1) ? $urandom_range(0, 31) : $urandom_range(0, 3));
            cur_wd[j] = $urandom;
         end
         cur_we  = 2'($urandom_range(0, 3));
         cur_iv  = 1'($urandom_range(0, 1));
         cur_ird = AW'($urandom_range(0, 1) ? $urandom_range(0, 31) : $urandom_range(0, 3));
         apply();
         #1;
         check_outputs();
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            check_outputs();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end else begin
            cyc();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/grg_mp.md
Name: grg_mp

Overview:
- Parametrised multi-port general register file, successor to the single-write/dual-read GPR bank.
- Serves wider-issue pipeline generations: NRD combinational read ports, NWR synchronous write ports, optional same-cycle write-to-read bypass, per-register busy scoreboard for RAW hazard detection.
- Sits between decode (read and issue) and writeback (write and clear busy).
- Register 0 is hardwired zero and never busy.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (power of two, >=2); AW = $clog2(NREG).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read returns stored value only.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rd_addr  input  NRD*AW  read addresses; port k uses slice [k*AW +: AW].
- rd_data  output  NRD*XLEN  read data; port k uses slice [k*XLEN +: XLEN].
- rd_busy  output  NRD  busy bit of the register addressed by each read port.
- we  input  NWR  write enables.
- wr_addr  input  NWR*AW  write addresses.
- wr_data  input  NWR*XLEN  write data.
- iss_valid  input  1  issue strobe: marks iss_rd busy.
- iss_rd  input  AW  destination register of the issuing instruction.
- busy_vec  output  NREG  full scoreboard, bit i = register i busy.

Behaviour:
- Reset: rst_n low asynchronously clears all registers and all busy bits to 0. Outputs follow combinationally: rd_data = 0, rd_busy = 0, busy_vec = 0. Writes and issues are ignored while rst_n is low. Deassertion takes effect at the next rising clk edge.
- Write:
  - On posedge clk, for each port j with we[j]=1 and wr_addr_j != 0, reg[wr_addr_j] <= wr_data_j.
  - Writes to address 0 are discarded.
  - When several enabled ports target the same address, the highest-index port wins.
- Read (combinational, 0-cycle latency):
  - Address 0 returns 0.
  - With BYPASS=1, if any enabled write port targets the read address (nonzero) in the same cycle, return that port's wr_data, using the highest-index matching port. Otherwise return the stored value.
  - With BYPASS=0, always return the stored value, i.e. the new value is visible the cycle after the write.
- Scoreboard:
  - Clear: on posedge clk, busy[wr_addr_j] <= 0 for every enabled write port j.
  - Set: busy[iss_rd] <= 1 when iss_valid=1 and iss_rd != 0.
  - If set and clear target the same register in the same cycle, set wins (a new producer supersedes the retiring one).
  - busy[0] is constant 0.
  - rd_busy[k] = busy[rd_addr_k], taken from current state with no bypass of the same-cycle clear. This is conservative and costs one stall cycle.
- Issuing to a register that is already busy is legal; it stays busy. The scoreboard is a single bit, not a count.
- Writing a register that is not busy is legal: data is updated and busy stays 0.
- Out-of-range addresses cannot occur because NREG is a power of two.

Decomposition:
- Shared package rf_pkg:
  - default constants XLEN_DEF=32, NREG_DEF=32.
  - function clog2_safe.
  - localparam REG_ZERO = 0.
- One natural sub-module: grg_scoreboard. It holds the busy-bit vector and the set/clear priority logic, with inputs clk, rst_n, iss_valid, iss_rd, we, wr_addr, and output busy_vec. The data array and read/bypass muxes stay in grg_mp.

Test Plan:
- Reset mid-operation: write 0xDEADBEEF to x5, issue x7, pull rst_n low between clock edges -> rd_data for x5 = 0 and busy_vec = 0 immediately, without waiting for a clock edge.
- Basic multi-port: port0 writes x3=0x11111111 and port1 writes x4=0x22222222 in the same cycle; next cycle read ports 0/1 at x3/x4 -> 0x11111111 / 0x22222222.
- Write conflict and x0:
  - Port0 and port1 both write x9 (0xAAAA0000, 0x5555FFFF) -> stored 0x5555FFFF.
  - Write x0 = 0xFFFFFFFF -> reading x0 returns 0.
- Bypass:
  - BYPASS=1: write x10 = 0x12345678 while reading x10 in the same cycle -> rd_data = 0x12345678 in that cycle.
  - BYPASS=0 instance, same stimulus -> old value in that cycle, 0x12345678 the next cycle.
- Scoreboard:
  - Issue x6 -> rd_busy on x6 = 1 the next cycle.
  - Write x6 -> busy clears the cycle after the write.
  - Issue x6 and write x6 in the same cycle -> busy remains 1.
  - Issue x0 -> busy_vec[0] = 0.
- Random regression: NWR=2, NRD=4, 10k cycles of random addresses and enables checked against a reference model, including reset pulses -> zero mismatches.
